// File: rtl/register_file_sb.sv
// Register file with per-register pending (scoreboard) bits, optional write-to-read
// forwarding, and a sequential whole-file clear sequencer.
//
// state | meaning
// IDLE  | normal access; writes, issues and clr_req are accepted
// CLEAR | zeroing reg[idx_q], one register per cycle
// DONE  | clear finished; clr_done pulses for this single cycle
module register_file_sb #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [WIDTH-1:0]  rs_data,
   output logic [WIDTH-1:0]  rt_data,
   output logic              rs_busy,
   output logic              rt_busy,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [31:0]       DEPTH_U  = 32'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam bit                ZR       = (ZERO_REG != 0);
   localparam bit                BP       = (BYPASS != 0);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0]  regs_q [DEPTH];
   logic [WIDTH-1:0]  regs_d [DEPTH];
   logic [DEPTH-1:0]  pend_q, pend_d;

   logic              wr_ok;
   logic              iss_ok;
   logic [ADDR_W-1:0] rd_addr [2];
   logic [WIDTH-1:0]  rd_data [2];
   logic              rd_busy [2];

   // Addresses past the end of the file, and r0 when hardwired, behave as absent.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (32'(a) < DEPTH_U) && !(ZR && (a == '0));
   endfunction

   assign wr_ok  = wr_en && addr_ok(wr_addr);
   assign iss_ok = issue_en && addr_ok(issue_addr);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      regs_d  = regs_q;
      pend_d  = pend_q;
      unique case (state_q)
         S_IDLE: begin
            if (wr_ok) begin
               regs_d[wr_addr] = wr_data;
               pend_d[wr_addr] = 1'b0;
            end
            // Issue is applied after the writeback so a same-address pair leaves it pending.
            if (iss_ok) begin
               pend_d[issue_addr] = 1'b1;
            end
            if (clr_req) begin
               pend_d  = '0;
               idx_d   = '0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            regs_d[idx_q] = '0;
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + ADDR_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         pend_q  <= '0;
         regs_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         regs_q  <= regs_d;
      end
   end

   assign rd_addr[0] = rs_addr;
   assign rd_addr[1] = rt_addr;

   // Reads are blanked while reset is held or a clear is running.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = '0;
         rd_busy[p] = 1'b0;
         if (rst && (state_q == S_IDLE) && addr_ok(rd_addr[p])) begin
            if (BP && wr_ok && (wr_addr == rd_addr[p])) begin
               rd_data[p] = wr_data;
            end else begin
               rd_data[p] = regs_q[rd_addr[p]];
               rd_busy[p] = pend_q[rd_addr[p]];
            end
         end
      end
   end

   assign rs_data  = rd_data[0];
   assign rt_data  = rd_data[1];
   assign rs_busy  = rd_busy[0];
   assign rt_busy  = rd_busy[1];
   assign clr_busy = (state_q != S_IDLE);
   assign clr_done = (state_q == S_DONE);

endmodule
